// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the FFT butterfly datapath.
package fp_pkg;

    localparam int         FP_EXP_W   = 8;
    localparam int         FP_FRAC_W  = 23;
    localparam int         FP_BIAS    = 127;
    localparam logic [7:0] FP_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    // Leading-zero count of the 27-bit working mantissa; 27 means all zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational single-precision adder: unpack, align, add/sub, normalize,
// round-to-nearest-even and exception detection. Subnormals flush to zero.
module fp_add_core
    import fp_pkg::*;
(
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [31:0] sum,
    output logic        ex
);

    fp32_t a, b;
    assign a = opa;
    assign b = opb;

    logic              a_zero, b_zero, a_big;
    logic              big_sign, small_sign;
    logic [7:0]        big_exp, small_exp, exp_diff;
    logic [23:0]       ma, mb, big_mant, small_mant;
    logic [26:0]       big_ext, small_al, norm, diff27;
    logic [53:0]       wide;
    logic [27:0]       sum28;
    logic [4:0]        lz;
    logic              cancel, rnd;
    logic [24:0]       mant25;
    logic [22:0]       frac_out;
    logic signed [9:0] res_exp;

    always_comb begin
        a_zero = (a.exp == 8'd0);
        b_zero = (b.exp == 8'd0);
        ma     = a_zero ? 24'd0 : {1'b1, a.frac};
        mb     = b_zero ? 24'd0 : {1'b1, b.frac};

        a_big      = (a.exp > b.exp) || ((a.exp == b.exp) && (ma >= mb));
        big_sign   = a_big ? a.sign : b.sign;
        small_sign = a_big ? b.sign : a.sign;
        big_exp    = a_big ? a.exp  : b.exp;
        small_exp  = a_big ? b.exp  : a.exp;
        big_mant   = a_big ? ma     : mb;
        small_mant = a_big ? mb     : ma;
        exp_diff   = big_exp - small_exp;

        // Bits shifted past the round position collapse into the sticky bit.
        wide = {small_mant, 3'b000, 27'd0} >> exp_diff;
        if (exp_diff > 8'd26) begin
            small_al = {26'd0, (small_mant != 24'd0)};
        end else begin
            small_al = wide[53:27] | {26'd0, (wide[26:0] != 27'd0)};
        end
        big_ext = {big_mant, 3'b000};

        res_exp = $signed({2'b00, big_exp});
        sum28   = 28'd0;
        diff27  = 27'd0;
        lz      = 5'd0;
        cancel  = 1'b0;
        if (big_sign == small_sign) begin
            sum28 = {1'b0, big_ext} + {1'b0, small_al};
            if (sum28[27]) begin
                norm    = {sum28[27:2], (sum28[1] | sum28[0])};
                res_exp = res_exp + 10'sd1;
            end else begin
                norm = sum28[26:0];
            end
        end else begin
            diff27  = big_ext - small_al;
            cancel  = (diff27 == 27'd0);
            lz      = lzc27(diff27);
            norm    = diff27 << lz;
            res_exp = res_exp - $signed({5'b00000, lz});
        end

        rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant25 = {1'b0, norm[26:3]} + {24'd0, rnd};
        if (mant25[24]) begin
            frac_out = mant25[23:1];
            res_exp  = res_exp + 10'sd1;
        end else begin
            frac_out = mant25[22:0];
        end

        sum = 32'd0;
        ex  = 1'b0;
        if ((a.exp == FP_EXP_MAX) || (b.exp == FP_EXP_MAX)) begin
            ex = 1'b1;
        end else if (a_zero && b_zero) begin
            sum = 32'd0;
        end else if (a_zero) begin
            sum = opb;
        end else if (b_zero) begin
            sum = opa;
        end else if (cancel || (res_exp <= 10'sd0)) begin
            sum = 32'd0;
        end else if (res_exp >= 10'sd255) begin
            ex = 1'b1;
        end else begin
            sum = {big_sign, res_exp[7:0], frac_out};
        end
    end

endmodule

// File: rtl/acc.sv
// Registered single-precision adder stage: Out = M1 + M2 one cycle later,
// EX flags Inf/NaN operands or overflow.
module acc
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] M1,
    input  logic [31:0] M2,
    output logic [31:0] Out,
    output logic        EX
);

    logic [31:0] sum_next;
    logic        ex_next;
    logic [31:0] out_reg;
    logic        ex_reg;

    fp_add_core u_core (
        .opa (M1),
        .opb (M2),
        .sum (sum_next),
        .ex  (ex_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= 32'd0;
            ex_reg  <= 1'b0;
        end else begin
            out_reg <= sum_next;
            ex_reg  <= ex_next;
        end
    end

    assign Out = out_reg;
    assign EX  = ex_reg;

endmodule

// File: tb/tb_acc.sv
// Self-checking bench for acc: directed vectors plus random operands checked
// against an exact wide-integer sum rounded to nearest-even.
module tb_acc;

    logic        clk;
    logic        rst_n;
    logic [31:0] M1, M2;
    logic [31:0] Out;
    logic        EX;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    logic [31:0] prev_out = 32'd0;
    logic        prev_ex  = 1'b0;

    acc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .M1    (M1),
        .M2    (M2),
        .Out   (Out),
        .EX    (EX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish before 500000");
        $fatal(1, "timeout");
    end

    // Exact reference: both operands as integers scaled to the smaller exponent,
    // summed exactly, then rounded to 24 significant bits (ties to even).
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        logic [299:0] av, bv, rv, q, rem, half;
        int ea, eb, emin, p, sh, ee;
        logic s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        r  = 32'd0;
        e  = 1'b0;
        if (ea == 255 || eb == 255) begin
            e = 1'b1;
        end else if (ea == 0 && eb == 0) begin
            r = 32'd0;
        end else if (ea == 0) begin
            r = b;
        end else if (eb == 0) begin
            r = a;
        end else begin
            emin = (ea < eb) ? ea : eb;
            av   = 300'({1'b1, a[22:0]}) << (ea - emin);
            bv   = 300'({1'b1, b[22:0]}) << (eb - emin);
            if (a[31] == b[31]) begin
                rv = av + bv; s = a[31];
            end else if (av >= bv) begin
                rv = av - bv; s = a[31];
            end else begin
                rv = bv - av; s = b[31];
            end
            if (rv != 300'd0) begin
                p = 0;
                for (int i = 0; i < 300; i++) if (rv[i]) p = i;
                ee = emin + p - 23;
                if (p > 23) begin
                    sh   = p - 23;
                    q    = rv >> sh;
                    rem  = rv - (q << sh);
                    half = 300'd1 << (sh - 1);
                    if (rem > half || (rem == half && q[0])) q = q + 300'd1;
                    if (q[24]) begin
                        q  = q >> 1;
                        ee = ee + 1;
                    end
                end else begin
                    q = rv << (23 - p);
                end
                if (ee >= 255) e = 1'b1;
                else if (ee > 0) r = {s, ee[7:0], q[22:0]};
            end
        end
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, req);
        end
    endtask

    // Called at posedge+1: drive operands, confirm the output still holds the
    // previous result, then check the new result just after the next edge.
    task automatic run_exp(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] req_out, input logic req_ex, input string tag);
        M1 = a;
        M2 = b;
        #1;
        check32({tag, "_hold_out"}, Out, prev_out);
        check1({tag, "_hold_ex"}, EX, prev_ex);
        @(posedge clk);
        #1;
        check32({tag, "_out"}, Out, req_out);
        check1({tag, "_ex"}, EX, req_ex);
        prev_out = req_out;
        prev_ex  = req_ex;
        n_txn++;
        $display("txn %0d %s: %h + %h -> Out=%h EX=%b", n_txn, tag, a, b, Out, EX);
    endtask

    task automatic run_model(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] r;
        logic        e;
        model(a, b, r, e);
        run_exp(a, b, r, e, tag);
    endtask

    function automatic int clampe(input int v);
        if (v < 1) return 1;
        if (v > 254) return 254;
        return v;
    endfunction

    initial begin
        int          ea, eb;
        logic [22:0] fa, fb;
        logic        sa, sb;

        rst_n = 1'b0;
        M1    = 32'd0;
        M2    = 32'd0;
        #1;
        check32("por_out", Out, 32'd0);
        check1("por_ex", EX, 1'b0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check32("zero_in_out", Out, 32'd0);
        check1("zero_in_ex", EX, 1'b0);

        run_exp(32'h4B7FFFFF, 32'h3F800000, 32'h4B800000, 1'b0, "exact_carry");
        run_exp(32'h4B7FFFFF, 32'h40000000, 32'h4B800000, 1'b0, "tie_even");
        run_model(32'h420151EC, 32'h4242147B, "mix_80");
        run_model(32'h406851EC, 32'h4090A3D7, "mix_8");
        run_model(32'h454277D7, 32'h453B8FD7, "mix_6112");
        run_model(32'h3F3AE148, 32'h3EB33333, "mix_1");
        run_model(32'hBF3AE148, 32'h3EC7AE14, "sgn_m034");
        run_model(32'hC207C28F, 32'h4243B852, "sgn_15");
        run_model(32'h4E6B79A3, 32'hCCEB79A3, "sgn_big");
        run_exp(32'hBF3AE148, 32'h3F3AE148, 32'h00000000, 1'b0, "cancel");
        run_exp(32'h7F800000, 32'h3EC7AE14, 32'h00000000, 1'b1, "inf_op");
        run_exp(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 1'b1, "overflow");
        run_exp(32'h7FC00000, 32'h00000000, 32'h00000000, 1'b1, "nan_zero");
        run_exp(32'h00000000, 32'hC0400000, 32'hC0400000, 1'b0, "zero_plus_x");
        run_exp(32'h80000000, 32'h00000000, 32'h00000000, 1'b0, "negz_plus_z");
        run_exp(32'h00812345, 32'h80800000, 32'h00000000, 1'b0, "underflow");

        // Asynchronous reset in the middle of traffic, away from any edge.
        run_exp(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, "pre_reset");
        #2 rst_n = 1'b0;
        #1;
        check32("async_rst_out", Out, 32'd0);
        check1("async_rst_ex", EX, 1'b0);
        M1 = 32'h40400000;
        M2 = 32'h40400000;
        @(posedge clk);
        #1;
        check32("rst_held_out", Out, 32'd0);
        check1("rst_held_ex", EX, 1'b0);
        rst_n    = 1'b1;
        prev_out = 32'd0;
        prev_ex  = 1'b0;
        run_model(32'h40400000, 32'h40400000, "post_reset");

        // Back-to-back random operations covering near-equal exponents,
        // cancellation, wide alignment, overflow/underflow edges and specials.
        for (int k = 0; k < 400; k++) begin
            ea = int'($urandom_range(1, 254));
            fa = 23'($urandom);
            fb = 23'($urandom);
            sa = 1'($urandom);
            sb = 1'($urandom);
            case ($urandom_range(0, 8))
                0: eb = ea;
                1, 2: eb = clampe(ea + int'($urandom_range(0, 6)) - 3);
                3: eb = int'($urandom_range(1, 254));
                4: eb = 0;
                5: eb = clampe(ea - int'($urandom_range(20, 30)));
                6: begin ea = int'($urandom_range(250, 254)); eb = ea; sb = sa; end
                7: begin ea = int'($urandom_range(1, 4)); eb = ea; sb = ~sa; end
                default: eb = 255;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                fb = fa ^ 23'($urandom_range(0, 15));
                sb = ~sa;
            end
            run_model({sa, 8'(ea), fa}, {sb, 8'(eb), fb}, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
